// File: rtl/fpu_div_iter.sv
// Iterative restoring floating-point divider (result = operand_a / operand_b).
// One quotient bit per cycle, round-to-nearest-even, IEEE-style exception
// flags, denormals flushed to zero, canonical quiet NaN on invalid inputs.
module fpu_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   operand_a,
    input  logic [EXP_W+MAN_W:0]   operand_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;          // significand incl. hidden bit
    localparam int QW = MAN_W + 3;          // quotient bits / remainder width
    localparam int EW = EXP_W + 2;          // signed working exponent
    localparam int CW = $clog2(QW + 1);

    localparam logic signed [EW-1:0] BIAS_S = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [QW-1:0]        rem_q, rem_d;
    logic [QW-1:0]        quo_q, quo_d;
    logic [SW-1:0]        mb_q, mb_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [W-1:0]         result_q, result_d;
    logic [4:0]           flags_q, flags_d;
    logic                 out_valid_q, out_valid_d;

    // Normalise, round to nearest even and range-check; returns {flags, result}.
    function automatic logic [W+4:0] round_pack(input logic [QW-1:0] q,
                                                input logic rem_nz,
                                                input logic sgn,
                                                input logic signed [EW-1:0] e_in);
        logic [MAN_W-1:0]     frac;
        logic [MAN_W:0]       fr;
        logic                 g;
        logic                 s;
        logic signed [EW-1:0] e;
        if (q[QW-1]) begin
            frac = q[QW-2:2];
            g    = q[1];
            s    = q[0] | rem_nz;
            e    = e_in;
        end else begin
            frac = q[QW-3:1];
            g    = q[0];
            s    = rem_nz;
            e    = e_in - ONE_S;
        end
        fr = {1'b0, frac} + (MAN_W+1)'(g & (s | frac[0]));
        // A carry out leaves the fraction at zero, i.e. significand 1.0.
        if (fr[MAN_W]) e = e + ONE_S;
        if (e >= EMAX_S)
            return {5'b00101, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (e[EW-1] || e == '0)
            return {5'b00011, sgn, {(W-1){1'b0}}};
        return {4'b0000, g | s, sgn, e[EXP_W-1:0], fr[MAN_W-1:0]};
    endfunction

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Next-state: operand capture and special cases, division step, rounding, handoff.
    always_comb begin
        logic             sa, sb, s;
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] fa, fb;
        logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [QW-1:0]    diff;
        logic             qbit;
        logic [W+4:0]     packed_res;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        mb_d        = mb_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;

        sa = operand_a[W-1];
        sb = operand_b[W-1];
        s  = sa ^ sb;
        ea = operand_a[W-2:MAN_W];
        eb = operand_b[W-2:MAN_W];
        fa = operand_a[MAN_W-1:0];
        fb = operand_b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);

        diff       = '0;
        qbit       = 1'b0;
        packed_res = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    flags_d     = 5'b00000;
                    if (a_nan || b_nan) begin
                        result_d = QNAN;
                    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        result_d = QNAN;
                        flags_d  = 5'b10000;
                    end else if (a_inf) begin
                        result_d = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (b_zero) begin
                        result_d = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_d  = 5'b01000;
                    end else if (b_inf || a_zero) begin
                        result_d = {s, {(W-1){1'b0}}};
                    end else begin
                        state_d     = DIVIDE;
                        out_valid_d = 1'b0;
                        rem_d       = {2'b00, 1'b1, fa};
                        mb_d        = {1'b1, fb};
                        quo_d       = '0;
                        cnt_d       = CW'(QW);
                        sign_d      = s;
                        exp_d       = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
                    end
                end
            end
            DIVIDE: begin
                if (rem_q >= {2'b00, mb_q}) begin
                    diff = rem_q - {2'b00, mb_q};
                    qbit = 1'b1;
                end else begin
                    diff = rem_q;
                    qbit = 1'b0;
                end
                rem_d = {diff[QW-2:0], 1'b0};
                quo_d = {quo_q[QW-2:0], qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ROUND;
            end
            ROUND: begin
                packed_res  = round_pack(quo_q, rem_q != '0, sign_q, exp_q);
                result_d    = packed_res[W-1:0];
                flags_d     = packed_res[W+4:W];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            mb_q        <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            mb_q        <= mb_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_fpu_div_iter.sv
// Self-checking bench for fpu_div_iter (binary32 defaults): directed cases,
// backpressure, mid-operation reset and randomized operands vs. a reference model.
module tb_fpu_div_iter;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;
    localparam int LAT   = MAN_W + 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_div_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: classify, then divide significands as whole integers.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [4:0] f,
                                    output int lat);
        logic   s;
        int     ea, eb, e, n;
        longint ma, mb, num, q, rm, sig;
        logic   g, st;
        logic   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        f   = 5'b00000;
        lat = 1;
        if (a_nan || b_nan) r = 32'h7FC00000;
        else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            r = 32'h7FC00000; f = 5'b10000;
        end else if (a_inf) r = {s, 8'hFF, 23'd0};
        else if (b_zero) begin
            r = {s, 8'hFF, 23'd0}; f = 5'b01000;
        end else if (b_inf || a_zero) r = {s, 31'd0};
        else begin
            lat = LAT;
            ma  = longint'({1'b1, a[22:0]});
            mb  = longint'({1'b1, b[22:0]});
            n   = (ma < mb) ? 1 : 0;
            e   = ea - eb + 127 - n;
            num = ma << (24 + n);
            q   = num / mb;
            rm  = num % mb;
            sig = q >> 1;
            g   = q[0];
            st  = (rm != 0);
            if (g && (st || sig[0])) sig = sig + 1;
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23;
                e   = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0}; f = 5'b00101;
            end else if (e <= 0) begin
                r = {s, 31'd0}; f = 5'b00011;
            end else begin
                r = {s, e[7:0], sig[22:0]}; f = {4'b0000, g | st};
            end
        end
    endfunction

    // Present operands, wait for acceptance and for the result (called #1 after an edge).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [4:0] f,
                          output int lat, output int accw);
        logic ok;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        accw      = 0;
        do begin
            ok = in_ready;
            @(posedge clk);
            accw++;
        end while (!ok && accw < 100);
        #1;
        in_valid = 1'b0;
        lat = 1;
        if (!ok) chk("accept_timeout", in_ready, 1);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 1);
        r = result;
        f = flags;
    endtask

    task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [4:0] ef, input int elat);
        logic [31:0] r;
        logic [4:0]  f;
        int lat, accw;
        run_op(a, b, r, f, lat, accw);
        chk({tag, "/res"}, r, er);
        chk({tag, "/flags"}, f, ef);
        chk({tag, "/lat"}, lat, elat);
        @(posedge clk);
        #1;
        chk({tag, "/drop"}, out_valid, 0);
    endtask

    task automatic rnd_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, er;
        logic [4:0]  f, ef;
        int lat, elat, accw;
        string tag;
        tag = $sformatf("rnd%0d %h/%h", idx, a, b);
        ref_div(a, b, er, ef, elat);
        run_op(a, b, r, f, lat, accw);
        chk({tag, " res"}, r, er);
        chk({tag, " flags"}, f, ef);
        chk({tag, " lat"}, lat, elat);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_fp();
        int   k;
        logic [7:0] e;
        logic [22:0] m;
        k = $urandom_range(0, 19);
        m = 23'($urandom);
        if (k == 0)       e = 8'd0;
        else if (k == 1)  begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = '0; end
        else if (k < 12)  e = 8'($urandom_range(100, 154));
        else              e = 8'($urandom_range(1, 254));
        if (k == 2) m = '0;
        return {1'($urandom), e, m};
    endfunction

    initial begin
        logic [31:0] r;
        logic [4:0]  f;
        int lat, accw;
        logic seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        operand_a = '0; operand_b = '0;
        @(posedge clk); #1;
        chk("rst/in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("rst/out_valid", out_valid, 0);
        chk("rst/result", result, 0);
        chk("rst/flags", flags, 0);
        rst = 1'b0;
        #1;
        chk("rst/in_ready_after", in_ready, 1);

        dir("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
        dir("-7.5/2.5", 32'hC0F00000, 32'h40200000, 32'hC0400000, 5'b00000, 28);
        dir("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
        dir("1/1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28);
        dir("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
        dir("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
        dir("-1/0",     32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 1);
        dir("nan/1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 1);
        dir("1/inf",    32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 1);
        dir("inf/inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 1);
        dir("-inf/2",   32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1);
        dir("ovf",      32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 5'b00101, 28);
        dir("unf",      32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);
        dir("denorm",   32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1);

        // Backpressure: result held, input ignored while waiting.
        out_ready = 1'b0;
        run_op(32'h40C00000, 32'h40000000, r, f, lat, accw);
        chk("bp/res", r, 32'h40400000);
        for (int i = 0; i < 10; i++) begin
            in_valid  = (i == 3);
            operand_a = 32'h3F800000;
            operand_b = 32'h00000000;
            @(posedge clk); #1;
            chk($sformatf("bp%0d/res", i), result, 32'h40400000);
            chk($sformatf("bp%0d/flags", i), flags, 0);
            chk($sformatf("bp%0d/valid", i), out_valid, 1);
            chk($sformatf("bp%0d/in_ready", i), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp/valid_fall", out_valid, 0);
        chk("bp/in_ready", in_ready, 1);
        run_op(32'h3F800000, 32'h3F800000, r, f, lat, accw);
        chk("bp/next_accw", accw, 1);
        chk("bp/next_res", r, 32'h3F800000);
        chk("bp/next_flags", f, 0);
        @(posedge clk); #1;

        // Reset during DIVIDE aborts the operation.
        operand_a = 32'h40C00000;
        operand_b = 32'h40000000;
        in_valid  = 1'b1;
        chk("rst_mid/accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid/in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid/out_valid", out_valid, 0);
        chk("rst_mid/in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("rst_mid/no_result", seen, 0);
        dir("rst_mid/6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);

        for (int i = 0; i < 60; i++) rnd_op(i, rand_fp(), rand_fp());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/fpu_div_iter.md
Name: fpu_div_iter

Overview:
- Parametrised, iterative restoring floating-point divider: result = operand_a / operand_b.
- Operands and result use an IEEE-754-style layout with configurable exponent and mantissa widths. Defaults give binary32.
- Adds a valid/ready handshake on input and output, round-to-nearest-even, exception flags and a canonical NaN.
- Sits in the FPU datapath alongside the adder/multiplier. It accepts one operation at a time.

Parameters:
EXP_W  8  exponent field width; bias B = 2^(EXP_W-1)-1
MAN_W  23  stored fraction width; significand is MAN_W+1 bits with the hidden 1
(Derived: W = 1+EXP_W+MAN_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
operand_a  input  W  dividend
operand_b  input  W  divisor
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result
result  output  W  quotient
flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset: one clock, synchronous, active-high.
  - When rst is sampled high: state=IDLE, out_valid=0, result=0, flags=0, internal registers cleared.
  - in_ready=0 while rst is high.
  - Reset aborts any operation in flight; no result is produced for it.
- States: IDLE, DIVIDE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture both operands.
  - Special-case operands go to DONE. All others go to DIVIDE.
- Operand classification:
  - Exponent field 0 means zero; denormals are flushed to signed zero.
  - All-ones exponent with zero fraction is inf.
  - All-ones exponent with nonzero fraction is NaN.
- Special results (sign = sa^sb unless NaN):
  - Any NaN input -> canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0); no flag.
  - 0/0 and inf/inf -> qNaN, invalid.
  - finite nonzero/0 -> ±inf, div_by_zero.
  - inf/finite -> ±inf.
  - finite/inf -> ±0.
  - 0/finite nonzero -> ±0.
- DIVIDE:
  - Remainder starts at ma (MAN_W+1 bits, zero-extended by 2); divisor is mb.
  - Exactly MAN_W+3 cycles, one quotient bit per cycle, MSB first: trial subtract; if non-negative, keep the difference and set bit=1; then shift the remainder left by 1.
  - Internal down-counter, MAN_W+3 down to 1; exits to ROUND when it reaches 1.
- ROUND (1 cycle):
  - If quotient MSB=0 (ma<mb), shift left 1 and decrement the exponent.
  - Keep MAN_W+1 significand bits plus guard; sticky = any remaining quotient bit OR remainder!=0.
  - Round to nearest even. A carry out of the significand increments the exponent and the significand becomes 1.0.
  - Exponent arithmetic is signed, EXP_W+2 bits: e = ea - eb + B (-1 on normalise, +1 on carry).
  - e >= 2^EXP_W-1 -> ±inf, overflow+inexact.
  - e <= 0 -> ±0, underflow+inexact (flush; no denormal output).
  - Otherwise inexact = guard|sticky.
- DONE:
  - out_valid=1; result and flags are held stable until out_ready is sampled high.
  - On that edge, out_valid=0 and the state returns to IDLE; in_ready=1 from the next cycle.
  - in_valid is ignored outside IDLE.
- Latency, measured from the acceptance edge to the out_valid rise:
  - Normal operands: MAN_W+5 edges (28 for defaults).
  - Special cases: 1 edge.
- Throughput: one operation per latency+1 cycles with out_ready held high.
- Simultaneous events:
  - rst has priority over every handshake.
  - out_ready arriving while out_valid=0 has no effect.

Test Plan:
1. Defaults: 0x40C00000/0x40000000 -> 0x40400000, flags 0, out_valid exactly 28 cycles after acceptance; 0xC0F00000/0x40200000 -> 0xC0400000.
2. Rounding: 0x3F800000/0x40400000 (1/3) -> 0x3EAAAAAB, inexact=1; 0x3F800000/0x3F800000 -> 0x3F800000, inexact=0.
3. Specials, each with out_valid 1 cycle after acceptance:
   - 0/0 -> 0x7FC00000, invalid.
   - 0x3F800000/0 -> 0x7F800000, div_by_zero.
   - 0xBF800000/0 -> 0xFF800000, div_by_zero.
   - 0x7FC00001/1.0 -> 0x7FC00000, no flags.
   - 1.0/0x7F800000 -> 0x00000000.
4. Range:
   - 0x7F7FFFFF/0x00800000 -> 0x7F800000, overflow+inexact.
   - 0x00800000/0x40000000 -> 0x00000000, underflow+inexact.
   - Denormal 0x00000001/1.0 -> 0x00000000.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0, a pulsed in_valid is ignored; raise out_ready -> out_valid falls next edge, next operation is accepted one cycle later.
6. Reset mid-DIVIDE (cycle 10) -> out_valid stays 0; after rst falls, in_ready=1 and the next operation (6.0/2.0) returns 0x40400000 at full latency.
